// File: rtl/chart_player_pkg.sv
// Shared types for the chart player: player states, note/chart layout and
// small helpers used to index the notes array safely.
package chart_player_pkg;

    localparam int NOTES_MAX       = 8;
    localparam int STEP_HZ_DEFAULT = 8;
    localparam int IDX_W           = $clog2(NOTES_MAX);
    localparam int CNT_W           = $clog2(NOTES_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_CHECK,
        ST_PLAY,
        ST_PAUSED,
        ST_FIN
    } PlayerState;

    // A note code of 0 is a rest (silent slot).
    typedef logic [7:0] Notes;

    typedef struct packed {
        logic [15:0] note_cnt;
    } ChartInfo;

    typedef struct packed {
        ChartInfo                info;
        Notes [NOTES_MAX-1:0]    notes;
    } Chart;

    // Note at a slot index; anything outside the stored array reads as a rest.
    function automatic Notes note_at(input Chart c, input int idx);
        if (idx >= 0 && idx < NOTES_MAX) begin
            return c.notes[IDX_W'(idx)];
        end
        return '0;
    endfunction

    // Playable note count: the stored count, clamped to the array length.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [15:0] n);
        if (n > 16'(NOTES_MAX)) begin
            return CNT_W'(NOTES_MAX);
        end
        return CNT_W'(n);
    endfunction

endpackage

// File: rtl/chart_player_step_ticker.sv
// Slot-rate divider: counts 0..DIV-1 while enabled and emits a one-cycle
// tick on the terminal count. Clear has priority over enable.
module step_ticker #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == CW'(DIV - 1));

    // Divider counter: frozen when disabled, wraps to 0 on the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/chart_player.sv
// Chart player: loads one chart through the storage read port, then steps
// through its notes at a fixed slot rate with pause/resume/stop support.
//
// Control semantics: start and stop are single-cycle pulses sampled on the
// rising edge; pause is a level. read_chart_id is a one-cycle read strobe and
// chart_data is taken as valid from the cycle after it, held thereafter
// because the strobe stays 0. done and err are one-cycle pulses.
module chart_player
    import chart_player_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int STEP_HZ = STEP_HZ_DEFAULT
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        stop,
    input  logic [7:0]  chart_id,
    output logic [7:0]  read_chart_id,
    input  Chart        chart_data,
    output Notes        current_note,
    output Notes        next_note,
    output logic [15:0] note_index,
    output logic        playing,
    output logic        done,
    output logic        err,
    output PlayerState  state_dbg
);

    localparam int SLOT_CYCLES = CLK_HZ / STEP_HZ;

    PlayerState       state;
    logic [IDX_W-1:0] index;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] new_cnt;
    logic             run_en;
    logic             tick_clr;
    logic             tick;
    logic             last_slot;
    int               idx_i;

    // Divider runs in PLAY/PAUSED only while neither pause nor stop is high.
    always_comb begin
        run_en    = (state == ST_PLAY || state == ST_PAUSED) && !pause && !stop;
        tick_clr  = (state == ST_IDLE) || (state == ST_CHECK);
        new_cnt   = clamp_cnt(chart_data.info.note_cnt);
        idx_i     = int'(index);
        last_slot = (idx_i == int'(cnt) - 1);
    end

    step_ticker #(
        .DIV (SLOT_CYCLES)
    ) u_ticker (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .en    (run_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign note_index = 16'(index);
    assign state_dbg  = state;

    // Player FSM with registered outputs; stop outranks pause, pause outranks tick.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            index         <= '0;
            cnt           <= '0;
            read_chart_id <= '0;
            current_note  <= '0;
            next_note     <= '0;
            playing       <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done          <= 1'b0;
            err           <= 1'b0;
            read_chart_id <= '0;
            if (stop && state != ST_IDLE) begin
                state        <= ST_IDLE;
                current_note <= '0;
                next_note    <= '0;
                playing      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (chart_id != 8'd0) begin
                                read_chart_id <= chart_id;
                                state         <= ST_REQ;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    ST_REQ:  state <= ST_WAIT;
                    ST_WAIT: state <= ST_CHECK;
                    ST_CHECK: begin
                        cnt   <= new_cnt;
                        index <= '0;
                        if (new_cnt == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state        <= ST_PLAY;
                            playing      <= 1'b1;
                            current_note <= note_at(chart_data, 0);
                            next_note    <= (new_cnt > CNT_W'(1)) ? note_at(chart_data, 1) : '0;
                        end
                    end
                    ST_PLAY, ST_PAUSED: begin
                        if (pause) begin
                            state        <= ST_PAUSED;
                            current_note <= '0;
                        end else if (tick) begin
                            if (last_slot) begin
                                state        <= ST_FIN;
                                done         <= 1'b1;
                                playing      <= 1'b0;
                                current_note <= '0;
                                next_note    <= '0;
                            end else begin
                                state        <= ST_PLAY;
                                index        <= index + 1'b1;
                                current_note <= note_at(chart_data, idx_i + 1);
                                next_note    <= (idx_i + 2 < int'(cnt)) ?
                                                note_at(chart_data, idx_i + 2) : '0;
                            end
                        end else begin
                            state        <= ST_PLAY;
                            current_note <= note_at(chart_data, idx_i);
                        end
                    end
                    ST_FIN:  state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chart_player.sv
// Bench for chart_player: a storage model feeds charts, directed scenarios
// push expected output-change events, and a monitor pops and compares them.
module tb_chart_player;
    import chart_player_pkg::*;

    localparam int CLK_HZ  = 100;
    localparam int STEP_HZ = 10;
    localparam logic [31:0] ANY_CYC = 32'hFFFF_FFFF;

    typedef struct packed {
        Notes        cur;
        Notes        nxt;
        logic [15:0] idx;
        logic        playing;
        logic        done;
        logic        err;
        logic [7:0]  rd;
    } snap_t;

    typedef struct packed {
        logic [31:0] cyc;
        snap_t       s;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  chart_id = '0;
    logic [7:0]  read_chart_id;
    Chart        chart_data = '0;
    Notes        current_note;
    Notes        next_note;
    logic [15:0] note_index;
    logic        playing;
    logic        done;
    logic        err;
    PlayerState  state_dbg;

    Chart        charts [4];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic        end_req = 1'b0;
    logic        end_done = 1'b0;
    snap_t       prev_s = '1;
    logic [EXP_W-1:0] exp_q [$];

    chart_player #(
        .CLK_HZ  (CLK_HZ),
        .STEP_HZ (STEP_HZ)
    ) dut (
        .clk           (clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .pause         (pause),
        .stop          (stop),
        .chart_id      (chart_id),
        .read_chart_id (read_chart_id),
        .chart_data    (chart_data),
        .current_note  (current_note),
        .next_note     (next_note),
        .note_index    (note_index),
        .playing       (playing),
        .done          (done),
        .err           (err),
        .state_dbg     (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Storage model: registered read, output held while the strobe is 0
    always @(posedge clk) begin
        if (read_chart_id != 8'd0 && read_chart_id < 8'd4) begin
            chart_data <= charts[read_chart_id[1:0]];
        end
    end

    // Monitor: every change of the observed outputs consumes one expected event
    always @(negedge clk) begin
        snap_t s;
        exp_t  e;
        s.cur     = current_note;
        s.nxt     = next_note;
        s.idx     = note_index;
        s.playing = playing;
        s.done    = done;
        s.err     = err;
        s.rd      = read_chart_id;
        if (s !== prev_s) begin
            prev_s = s;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d got cur=%h nxt=%h idx=%0d play=%b done=%b err=%b rd=%0d expected no event",
                         cyc, s.cur, s.nxt, s.idx, s.playing, s.done, s.err, s.rd);
            end else begin
                e = exp_t'(exp_q.pop_front());
                if (s !== e.s || (e.cyc != ANY_CYC && 32'(cyc) != e.cyc)) begin
                    $display("FAIL event cyc=%0d got cur=%h nxt=%h idx=%0d play=%b done=%b err=%b rd=%0d ; required cyc=%0d cur=%h nxt=%h idx=%0d play=%b done=%b err=%b rd=%0d",
                             cyc, s.cur, s.nxt, s.idx, s.playing, s.done, s.err, s.rd,
                             e.cyc, e.s.cur, e.s.nxt, e.s.idx, e.s.playing, e.s.done, e.s.err, e.s.rd);
                end else begin
                    passes++;
                end
            end
        end
        if (end_req && !end_done) begin
            checks++;
            if (exp_q.size() != 0) begin
                $display("FAIL drain got %0d events outstanding required 0", exp_q.size());
            end else begin
                passes++;
            end
            end_done = 1'b1;
        end
    end

    task automatic push(input int c, input Notes cur, input Notes nxt, input int idx,
                        input logic pl, input logic dn, input logic er, input logic [7:0] rd);
        exp_t e;
        e.cyc       = (c < 0) ? ANY_CYC : 32'(c);
        e.s.cur     = cur;
        e.s.nxt     = nxt;
        e.s.idx     = 16'(idx);
        e.s.playing = pl;
        e.s.done    = dn;
        e.s.err     = er;
        e.s.rd      = rd;
        exp_q.push_back(EXP_W'(e));
    endtask

    // Read strobe cycle and its falling edge, with the index still held
    task automatic push_load(input int t, input logic [7:0] id, input int held);
        push(t + 1, 8'h00, 8'h00, held, 1'b0, 1'b0, 1'b0, id);
        push(t + 2, 8'h00, 8'h00, held, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Full natural play of chart 1: C4, G4, rest, 10 cycles each
    task automatic push_chart1(input int t, input int held);
        push_load(t, 8'd1, held);
        push(t + 4,  8'h3C, 8'h43, 0, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 14, 8'h43, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 24, 8'h00, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 34, 8'h00, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'd0);
        push(t + 35, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Drivers: all called at 1 time unit after a rising edge
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] id, output int t);
        t        = cyc;
        start    = 1'b1;
        chart_id = id;
        step_to(t + 1);
        start    = 1'b0;
        chart_id = '0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int t_ign;
        for (int i = 0; i < 4; i++) charts[i] = '0;
        charts[1].info.note_cnt = 16'd3;
        charts[1].notes[0] = 8'h3C;
        charts[1].notes[1] = 8'h43;
        charts[1].notes[2] = 8'h00;
        charts[2].info.note_cnt = 16'd0;
        for (int i = 0; i < NOTES_MAX; i++) charts[2].notes[i] = 8'h55;
        charts[3].info.note_cnt = 16'(NOTES_MAX + 5);
        for (int i = 0; i < NOTES_MAX; i++) charts[3].notes[i] = 8'h40 + 8'(i);

        // Reset state: every output low
        push(-1, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        step_to(cyc + 2);

        // Basic play, with a start during play that must be ignored
        pulse_start(8'd1, t);
        push_chart1(t, 0);
        step_to(t + 10);
        pulse_start(8'd3, t_ign);
        wait_drain(60);

        // Invalid id: err pulse only
        pulse_start(8'd0, t);
        push(t + 1, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b1, 8'd0);
        push(t + 2, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'd0);
        wait_drain(20);

        // Empty chart: done at T+4, no note ever sounds
        pulse_start(8'd2, t);
        push_load(t, 8'd2, 2);
        push(t + 4, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 8'd0);
        push(t + 5, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'd0);
        wait_drain(20);

        // Pause for 25 cycles starting 3 cycles into slot 1
        pulse_start(8'd1, t);
        push_load(t, 8'd1, 0);
        push(t + 4,  8'h3C, 8'h43, 0, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 14, 8'h43, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 18, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 43, 8'h43, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 49, 8'h00, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 59, 8'h00, 8'h00, 2, 1'b0, 1'b1, 1'b0, 8'd0);
        push(t + 60, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'd0);
        step_to(t + 17);
        pause = 1'b1;
        step_to(t + 42);
        pause = 1'b0;
        wait_drain(60);

        // Stop in the same cycle as the final tick: no done pulse
        pulse_start(8'd1, t);
        push_load(t, 8'd1, 2);
        push(t + 4,  8'h3C, 8'h43, 0, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 14, 8'h43, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 24, 8'h00, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 34, 8'h00, 8'h00, 2, 1'b0, 1'b0, 1'b0, 8'd0);
        step_to(t + 33);
        stop = 1'b1;
        step_to(t + 34);
        stop = 1'b0;
        wait_drain(30);

        // Asynchronous reset at index 2, then a clean replay from index 0
        pulse_start(8'd1, t);
        push_load(t, 8'd1, 2);
        push(t + 4,  8'h3C, 8'h43, 0, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 14, 8'h43, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 24, 8'h00, 8'h00, 2, 1'b1, 1'b0, 1'b0, 8'd0);
        push(t + 26, 8'h00, 8'h00, 0, 1'b0, 1'b0, 1'b0, 8'd0);
        step_to(t + 26);
        #1;
        sys_rst_n = 1'b0;
        step_to(t + 28);
        sys_rst_n = 1'b1;
        pulse_start(8'd1, t);
        push_chart1(t, 0);
        wait_drain(60);

        // Note count above the array length: clamped, lookahead 0 in last slot
        pulse_start(8'd3, t);
        push_load(t, 8'd3, 2);
        for (int k = 0; k < NOTES_MAX; k++) begin
            push(t + 4 + 10 * k, 8'h40 + 8'(k), (k < NOTES_MAX - 1) ? 8'h41 + 8'(k) : 8'h00,
                 k, 1'b1, 1'b0, 1'b0, 8'd0);
        end
        push(t + 4 + 10 * NOTES_MAX, 8'h00, 8'h00, NOTES_MAX - 1, 1'b0, 1'b1, 1'b0, 8'd0);
        push(t + 5 + 10 * NOTES_MAX, 8'h00, 8'h00, NOTES_MAX - 1, 1'b0, 1'b0, 1'b0, 8'd0);
        wait_drain(120);

        // Final report
        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
